// File: rtl/fb_pkg.sv
// Shared encodings and elaboration-time helpers for the N-slot frame buffer controller.
package fb_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_WAIT = 2'd2
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_READ = 1'b1
   } rd_state_t;

   function automatic int slot_w(input int nbufs);
      return (nbufs <= 2) ? 1 : $clog2(nbufs);
   endfunction

   function automatic int cnt_w(input int size);
      return $clog2(size + 1);
   endfunction

   // Only ever called with constants, so the multiply folds away at elaboration.
   function automatic longint slot_base(input int base, input int size, input int s);
      return longint'(base) + (longint'(s) * longint'(size));
   endfunction

endpackage

// File: rtl/fb_slot_alloc.sv
// Combinational next-slot picker: first free slot scanning forward from the
// slot just written, skipping the reader's held slot and a slot being claimed.
module fb_slot_alloc
   import fb_pkg::*;
#(
   parameter int NUM_BUFS = 3,
   localparam int SLOT_W  = slot_w(NUM_BUFS)
)(
   input  logic [SLOT_W-1:0] i_wr_slot,
   input  logic [SLOT_W-1:0] i_rd_slot,
   input  logic              i_rd_busy,
   input  logic              i_claim,
   input  logic [SLOT_W-1:0] i_latest,
   output logic [SLOT_W-1:0] o_next,
   output logic              o_found
);

   logic [SLOT_W:0]   w_raw;
   logic [SLOT_W:0]   w_sum;
   logic [SLOT_W-1:0] w_cand;
   logic              w_ok;

   // Descending scan so the nearest acceptable candidate is the one that sticks.
   always_comb begin
      o_next  = i_wr_slot;
      o_found = 1'b0;
      w_raw   = '0;
      w_sum   = '0;
      w_cand  = '0;
      w_ok    = 1'b0;
      for (int k = NUM_BUFS - 1; k >= 1; k--) begin
         w_raw   = {1'b0, i_wr_slot} + (SLOT_W+1)'(k);
         w_sum   = (w_raw >= (SLOT_W+1)'(NUM_BUFS)) ? (w_raw - (SLOT_W+1)'(NUM_BUFS)) : w_raw;
         w_cand  = w_sum[SLOT_W-1:0];
         w_ok    = !((i_rd_busy && (w_cand == i_rd_slot)) || (i_claim && (w_cand == i_latest)));
         o_next  = w_ok ? w_cand : o_next;
         o_found = o_found | w_ok;
      end
   end

endmodule

// File: rtl/frame_buf_nslot.sv
// N-slot frame buffer address controller: round-robin writer, latest-frame reader.
// Optional frame statistics (drop/repeat counters) enabled by defining FB_STATS_EN.
module frame_buf_nslot
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH = 29,
   parameter int BASE_ADDR  = 2,
   parameter int BUF_SIZE   = 230400,
   parameter int NUM_BUFS   = 3,
   localparam int SLOT_W    = slot_w(NUM_BUFS)
)(
   input  logic                  wr_clk,
   input  logic                  reset,
   input  logic                  i_wr_req,
   input  logic                  i_wr_rdy,
   input  logic                  i_rd_req,
   input  logic                  i_rd_rdy,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [SLOT_W-1:0]     o_wr_slot,
   output logic                  o_wr_frame_done,
   output logic                  o_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic [SLOT_W-1:0]     o_rd_slot,
   output logic                  o_rd_frame_done,
   output logic                  o_frame_vld
`ifdef FB_STATS_EN
   ,
   output logic [15:0]           o_drop_cnt,
   output logic [15:0]           o_repeat_cnt
`endif
);

   localparam int CNT_W = cnt_w(BUF_SIZE);
   localparam int NTAB  = 2 ** SLOT_W;

   wr_state_t             r_wst;
   rd_state_t             r_rst;
   logic [SLOT_W-1:0]     r_wr_slot;
   logic [SLOT_W-1:0]     r_rd_slot;
   logic [SLOT_W-1:0]     r_latest;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [CNT_W-1:0]      r_wr_cnt;
   logic [CNT_W-1:0]      r_rd_cnt;
   logic                  r_wr_done;
   logic                  r_rd_done;
   logic                  r_frame_vld;

   logic [ADDR_WIDTH-1:0] w_base [NTAB];
   logic                  w_wr_beat;
   logic                  w_rd_beat;
   logic                  w_wr_last;
   logic                  w_rd_last;
   logic                  w_claim;
   logic                  w_rd_busy;
   logic [SLOT_W-1:0]     w_next;
   logic                  w_found;

   // Constant slot base table; unused encodings alias slot 0.
   for (genvar g = 0; g < NTAB; g++) begin : g_base
      assign w_base[g] = ADDR_WIDTH'(slot_base(BASE_ADDR, BUF_SIZE, (g < NUM_BUFS) ? g : 0));
   end

   assign o_wr_en   = (r_wst == W_FILL) && i_wr_req;
   assign o_rd_en   = (r_rst == R_READ) && i_rd_req;
   assign w_wr_beat = o_wr_en && i_wr_rdy;
   assign w_rd_beat = o_rd_en && i_rd_rdy;
   assign w_wr_last = w_wr_beat && (r_wr_cnt == CNT_W'(BUF_SIZE - 1));
   assign w_rd_last = w_rd_beat && (r_rd_cnt == CNT_W'(BUF_SIZE - 1));
   assign w_claim   = (r_rst == R_IDLE) && i_rd_req && r_frame_vld;
   assign w_rd_busy = (r_rst == R_READ);

   fb_slot_alloc #(
      .NUM_BUFS (NUM_BUFS)
   ) u_alloc (
      .i_wr_slot (r_wr_slot),
      .i_rd_slot (r_rd_slot),
      .i_rd_busy (w_rd_busy),
      .i_claim   (w_claim),
      .i_latest  (r_latest),
      .o_next    (w_next),
      .o_found   (w_found)
   );

   // Writer FSM: fill, publish, move to a free slot or wait for the reader.
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_wst       <= W_IDLE;
         r_wr_slot   <= '0;
         r_wr_addr   <= ADDR_WIDTH'(BASE_ADDR);
         r_wr_cnt    <= '0;
         r_wr_done   <= 1'b0;
         r_latest    <= '0;
         r_frame_vld <= 1'b0;
      end else begin
         r_wr_done <= 1'b0;
         case (r_wst)
            W_IDLE: begin
               if (i_wr_req) r_wst <= W_FILL;
            end
            W_FILL: begin
               if (w_wr_last) begin
                  r_wr_done   <= 1'b1;
                  r_latest    <= r_wr_slot;
                  r_frame_vld <= 1'b1;
                  r_wr_cnt    <= '0;
                  if (w_found) begin
                     r_wr_slot <= w_next;
                     r_wr_addr <= w_base[w_next];
                  end else begin
                     r_wst <= W_WAIT;
                  end
               end else if (w_wr_beat) begin
                  r_wr_cnt  <= r_wr_cnt + CNT_W'(1);
                  r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
               end
            end
            W_WAIT: begin
               if (w_found) begin
                  r_wst     <= W_FILL;
                  r_wr_slot <= w_next;
                  r_wr_addr <= w_base[w_next];
               end
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   // Reader FSM: claim the registered latest frame, stream it, release.
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_rst     <= R_IDLE;
         r_rd_slot <= '0;
         r_rd_addr <= ADDR_WIDTH'(BASE_ADDR);
         r_rd_cnt  <= '0;
         r_rd_done <= 1'b0;
      end else begin
         r_rd_done <= 1'b0;
         case (r_rst)
            R_IDLE: begin
               if (w_claim) begin
                  r_rst     <= R_READ;
                  r_rd_slot <= r_latest;
                  r_rd_addr <= w_base[r_latest];
                  r_rd_cnt  <= '0;
               end
            end
            R_READ: begin
               if (w_rd_last) begin
                  r_rd_done <= 1'b1;
                  r_rst     <= R_IDLE;
                  r_rd_cnt  <= '0;
               end else if (w_rd_beat) begin
                  r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
                  r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
               end
            end
            default: r_rst <= R_IDLE;
         endcase
      end
   end

   assign o_wr_addr       = r_wr_addr;
   assign o_wr_slot       = r_wr_slot;
   assign o_wr_frame_done = r_wr_done;
   assign o_rd_addr       = r_rd_addr;
   assign o_rd_slot       = r_rd_slot;
   assign o_rd_frame_done = r_rd_done;
   assign o_frame_vld     = r_frame_vld;

`ifdef FB_STATS_EN
   logic        r_latest_read;
   logic [15:0] r_drop_cnt;
   logic [15:0] r_repeat_cnt;

   // A same-cycle claim takes the old latest, so that frame counts as read, not dropped.
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_latest_read <= 1'b0;
         r_drop_cnt    <= 16'd0;
         r_repeat_cnt  <= 16'd0;
      end else begin
         if (w_wr_last) begin
            r_latest_read <= 1'b0;
         end else if (w_claim) begin
            r_latest_read <= 1'b1;
         end
         if (w_wr_last && r_frame_vld && !r_latest_read && !w_claim && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
         if (w_claim && r_latest_read && (r_repeat_cnt != 16'hFFFF)) begin
            r_repeat_cnt <= r_repeat_cnt + 16'd1;
         end
      end
   end

   assign o_drop_cnt   = r_drop_cnt;
   assign o_repeat_cnt = r_repeat_cnt;
`endif

endmodule
